// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and writer FSM encoding.
// Also imported by the pixel readout path.
package fb_pkg;

    localparam int H_RES   = 800;
    localparam int V_RES   = 600;
    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 12;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_rect_writer.sv
// Rectangle-fill writer: clips a command to the screen and emits
// one row-major pixel write per cycle to the frame-buffer port.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [PIX_W-1:0]   cmd_color,
    input  logic               hold,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    output logic               busy,
    output logic               done
);

    localparam int EW = COORD_W + 1;
    localparam logic [EW-1:0]     H_LIM  = EW'(H_RES);
    localparam logic [EW-1:0]     V_LIM  = EW'(V_RES);
    localparam logic [EW-1:0]     ONE    = EW'(1);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    fb_state_t state, state_d;

    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
    logic [PIX_W-1:0]   color_q;
    logic [EW-1:0]      w_clip, h_clip;
    logic [EW-1:0]      col, row;
    logic [ADDR_W-1:0]  row_base;

    logic [EW-1:0] x_ext, y_ext, w_ext, h_ext;
    logic [EW-1:0] w_room, h_room, w_fit, h_fit;
    logic          is_empty, last_col, last_row, step;

    // 11-bit arithmetic so H_RES - x never wraps for x near the edge
    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign w_ext  = {1'b0, w_q};
    assign h_ext  = {1'b0, h_q};
    assign w_room = H_LIM - x_ext;
    assign h_room = V_LIM - y_ext;
    assign w_fit  = (w_ext < w_room) ? w_ext : w_room;
    assign h_fit  = (h_ext < h_room) ? h_ext : h_room;

    assign is_empty = (x_ext >= H_LIM) | (y_ext >= V_LIM)
                    | (w_q == '0) | (h_q == '0);

    assign last_col = (col == w_clip - ONE);
    assign last_row = (row == h_clip - ONE);
    assign step     = (state == S_FILL) & ~hold;

    assign wr_en   = step & ~rst;
    assign wr_addr = row_base + ADDR_W'(x_q) + ADDR_W'(col);
    assign wr_data = color_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d = is_empty ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (step && last_col && last_row) state_d = S_DONE;
            end
            S_DONE: begin
                done    = ~rst;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            w_clip   <= '0;
            h_clip   <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                x_q     <= cmd_x;
                y_q     <= cmd_y;
                w_q     <= cmd_w;
                h_q     <= cmd_h;
                color_q <= cmd_color;
            end
            if (state == S_SETUP) begin
                w_clip   <= w_fit;
                h_clip   <= h_fit;
                col      <= '0;
                row      <= '0;
                row_base <= ADDR_W'(y_q) * H_STEP;
            end
            if (step) begin
                if (last_col) begin
                    col      <= '0;
                    row      <= row + ONE;
                    row_base <= row_base + H_STEP;
                end else begin
                    col <= col + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer with an address/data scoreboard.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x = '0;
    logic [COORD_W-1:0] cmd_y = '0;
    logic [COORD_W-1:0] cmd_w = '0;
    logic [COORD_W-1:0] cmd_h = '0;
    logic [PIX_W-1:0]   cmd_color = '0;
    logic               hold = 1'b0;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [PIX_W-1:0]   wr_data;
    logic               busy;
    logic               done;

    fb_rect_writer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .hold(hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_a[$];
    int exp_d[$];
    int wr_cyc_q[$];
    int done_cyc_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cyc_q.push_back(cyc);
            chk("write_expected", int'(exp_a.size() != 0), 1);
            if (exp_a.size() != 0) begin
                chk("wr_addr", int'(wr_addr), exp_a.pop_front());
                chk("wr_data", int'(wr_data), exp_d.pop_front());
            end
        end
        if (done) done_cyc_q.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int y, input int w,
                        input int h, input int c, output int acc);
        int k;
        cmd_x     = COORD_W'(x);
        cmd_y     = COORD_W'(y);
        cmd_w     = COORD_W'(w);
        cmd_h     = COORD_W'(h);
        cmd_color = PIX_W'(c);
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 100) begin
            tick(1);
            k++;
        end
        chk("accept_timeout", int'(cmd_ready), 1);
        acc = cyc;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done_cyc_q.size() <= base && k < 200) begin
            tick(1);
            k++;
        end
        chk("done_timeout", int'(done_cyc_q.size() > base), 1);
    endtask

    int acc, acc_b, bw, bd;

    initial begin
        tick(1);
        chk("wr_en_in_reset", int'(wr_en), 0);
        tick(2);
        rst = 1'b0;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        // basic 3x2 fill
        push(16010, 'hF00); push(16011, 'hF00); push(16012, 'hF00);
        push(16810, 'hF00); push(16811, 'hF00); push(16812, 'hF00);
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(10, 20, 3, 2, 'hF00, acc);
        chk("basic_busy", int'(busy), 1);
        wait_done(bd);
        chk("basic_nwr", wr_cyc_q.size() - bw, 6);
        if (wr_cyc_q.size() - bw == 6) begin
            chk("basic_first_wr", wr_cyc_q[bw], acc + 2);
            chk("basic_last_wr", wr_cyc_q[bw + 5], acc + 7);
        end
        chk("basic_done_cyc", done_cyc_q[bd], acc + 8);
        chk("basic_ready_cyc", cyc, acc + 9);
        chk("basic_ready", int'(cmd_ready), 1);
        tick(2);
        chk("basic_done_once", done_cyc_q.size() - bd, 1);

        // clipped at bottom-right corner
        push(479998, 'h0F0); push(479999, 'h0F0);
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(798, 599, 5, 5, 'h0F0, acc);
        wait_done(bd);
        chk("clip_nwr", wr_cyc_q.size() - bw, 2);
        chk("clip_done_cyc", done_cyc_q[bd], acc + 4);

        // empty commands
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(800, 0, 4, 4, 'h123, acc);
        wait_done(bd);
        chk("empty_x_done_cyc", done_cyc_q[bd], acc + 2);
        send(0, 0, 0, 3, 'h123, acc);
        wait_done(bd + 1);
        chk("empty_w_done_cyc", done_cyc_q[bd + 1], acc + 2);
        chk("empty_nwr", wr_cyc_q.size() - bw, 0);

        // hold for three cycles after the first write
        push(4005, 'h5A5); push(4006, 'h5A5);
        push(4805, 'h5A5); push(4806, 'h5A5);
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(5, 5, 2, 2, 'h5A5, acc);
        tick(2);
        hold = 1'b1;
        tick(3);
        hold = 1'b0;
        wait_done(bd);
        chk("hold_nwr", wr_cyc_q.size() - bw, 4);
        if (wr_cyc_q.size() - bw == 4) begin
            chk("hold_wr0", wr_cyc_q[bw], acc + 2);
            chk("hold_wr1", wr_cyc_q[bw + 1], acc + 6);
            chk("hold_wr3", wr_cyc_q[bw + 3], acc + 8);
        end
        chk("hold_done_cyc", done_cyc_q[bd], acc + 9);

        // reset during the third write of a 4x4 fill
        push(800, 'h777); push(801, 'h777);
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(0, 1, 4, 4, 'h777, acc);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstmid_ready", int'(cmd_ready), 1);
        chk("rstmid_busy", int'(busy), 0);
        tick(10);
        chk("rstmid_nwr", wr_cyc_q.size() - bw, 2);
        chk("rstmid_no_done", done_cyc_q.size() - bd, 0);
        push(0, 'h123);
        send(0, 0, 1, 1, 'h123, acc);
        wait_done(bd);
        chk("after_rst_nwr", wr_cyc_q.size() - bw, 3);

        // back-to-back with cmd_valid held through the first fill
        push(80100, 'hABC); push(80101, 'hABC);
        push(479200, 'h00F); push(479201, 'h00F); push(479202, 'h00F);
        bw = wr_cyc_q.size(); bd = done_cyc_q.size();
        send(100, 100, 2, 1, 'hABC, acc);
        send(0, 599, 3, 1, 'h00F, acc_b);
        chk("b2b_accept_cyc", acc_b, done_cyc_q[bd] + 1);
        wait_done(bd + 1);
        chk("b2b_nwr", wr_cyc_q.size() - bw, 5);
        if (wr_cyc_q.size() - bw == 5) begin
            chk("b2b_first_wr_b", wr_cyc_q[bw + 2], acc_b + 2);
            chk("b2b_no_overlap", int'(wr_cyc_q[bw + 1] < acc_b), 1);
        end

        tick(3);
        chk("scoreboard_empty", exp_a.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
